// File: rtl/param_reg_file.sv
// Parameterised 2-read/1-write register file with registered reads and a one-pass clear sweep.
// Optional write-first bypass: define PARAM_REG_FILE_BYPASS_EN (default build is read-first).
module param_reg_file #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] SrcReg1,
    input  logic [ADDR_W-1:0] SrcReg2,
    input  logic [ADDR_W-1:0] DstReg,
    input  logic              WriteReg,
    input  logic [DATA_W-1:0] DstData,
    input  logic              clr,
    output logic [DATA_W-1:0] SrcData1,
    output logic [DATA_W-1:0] SrcData2,
    output logic              busy
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] sweep_q, sweep_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd1_q, rd1_d;
    logic [DATA_W-1:0] rd2_q, rd2_d;
    logic              wr_en;

    assign busy     = (state_q == CLEAR);
    assign SrcData1 = rd1_q;
    assign SrcData2 = rd2_q;

    // Writes are locked out for the whole sweep, and address 0 is read-only when hardwired.
    assign wr_en = WriteReg && !clr && !busy && !(ZERO_REG && (DstReg == '0));

    // NOTE: every variable assigned in an always_comb gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        case (state_q)
            IDLE: begin
                if (clr) begin
                    state_d = CLEAR;
                    sweep_d = '0;
                end
            end
            CLEAR: begin
                if (sweep_q == LAST_ADDR) begin
                    state_d = IDLE;
                    sweep_d = '0;
                end else begin
                    sweep_d = sweep_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                sweep_d = '0;
            end
        endcase
    end

    always_comb begin
        rd1_d = mem_q[SrcReg1];
        rd2_d = mem_q[SrcReg2];
`ifdef PARAM_REG_FILE_BYPASS_EN
        if (wr_en && (DstReg == SrcReg1)) rd1_d = DstData;
        if (wr_en && (DstReg == SrcReg2)) rd2_d = DstData;
`endif
        if (ZERO_REG && (SrcReg1 == '0)) rd1_d = '0;
        if (ZERO_REG && (SrcReg2 == '0)) rd2_d = '0;
    end

    // NOTE: the storage array is reset explicitly because reset must zero every register
    // on the same edge; sequential state is only ever assigned with <=.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sweep_q <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            if (state_q == CLEAR) begin
                mem_q[sweep_q] <= '0;
            end else if (wr_en) begin
                mem_q[DstReg] <= DstData;
            end
        end
    end

endmodule

// File: doc/param_reg_file.md
PARAM_REG_FILE -- requirements
Module: param_reg_file

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the width of each register and data port in bits.
REQ-002 Parameter ADDR_W, default 4, SHALL set the address width; DEPTH = 2**ADDR_W registers.
REQ-003 Parameter ZERO_REG, default 0, SHALL hardwire register 0 to zero when set to 1.
REQ-004 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-006 SrcReg1  input  ADDR_W  SHALL be the read port 1 address.
REQ-007 SrcReg2  input  ADDR_W  SHALL be the read port 2 address.
REQ-008 DstReg  input  ADDR_W  SHALL be the write address.
REQ-009 WriteReg  input  1  SHALL be the write enable.
REQ-010 DstData  input  DATA_W  SHALL be the write data.
REQ-011 clr  input  1  SHALL be the request to start a clear sweep of all registers.
REQ-012 SrcData1  output  DATA_W  SHALL be the registered read data for port 1.
REQ-013 SrcData2  output  DATA_W  SHALL be the registered read data for port 2.
REQ-014 busy  output  1  SHALL be high while a clear sweep is in progress.

Function
REQ-015 Reads SHALL have 1-cycle latency: SrcDataN is registered on the edge where SrcRegN is sampled.
REQ-016 A write SHALL be accepted when WriteReg=1, clr=0 and busy=0; DstData is stored at DstReg on that edge.
REQ-017 A write with clr=1 or busy=1 SHALL be dropped with no effect on storage or bypass.
REQ-018 When ZERO_REG=1, writes to address 0 SHALL be dropped, and reads of address 0 SHALL return 0, including under bypass.
REQ-019 Both read ports SHALL operate independently; equal addresses on both ports SHALL return identical data.
REQ-020 The FSM SHALL have two states. IDLE->CLEAR occurs on clr=1. CLEAR->IDLE occurs after the edge that clears address DEPTH-1.
REQ-021 In CLEAR, a sweep counter SHALL zero address 0 on the first CLEAR edge and increment by one per cycle, so the sweep takes DEPTH cycles.
REQ-022 busy SHALL be 1 exactly during the DEPTH cycles spent in CLEAR.
REQ-023 clr asserted while in CLEAR SHALL be ignored, with no restart and no extension of the sweep.
REQ-024 Reads during CLEAR SHALL continue to be served: already-swept addresses return 0, unswept addresses return old contents.
REQ-025 The sweep counter SHALL be ADDR_W bits wide and SHALL NOT wrap past DEPTH-1 into a second pass.

Reset
REQ-026 rst=1 SHALL zero all DEPTH registers, SrcData1 and SrcData2 on the same edge.
REQ-027 rst=1 SHALL force the FSM to IDLE with busy=0 and sweep counter 0.
REQ-028 rst=1 SHALL take priority over clr and WriteReg, including mid-sweep, which aborts the sweep.

Configuration
REQ-029 With macro PARAM_REG_FILE_BYPASS_EN defined, a read on the same edge as an accepted write to the same address SHALL return DstData (write-first).
REQ-030 With PARAM_REG_FILE_BYPASS_EN undefined, that read SHALL return the pre-write contents (read-first); the new value is visible from the next read.

Verification
REQ-031 Write 0xBEEF to r5; next cycle read r5 on both ports -> SrcData1 = SrcData2 = 0xBEEF one cycle after the address.
REQ-032 Same-edge write of 0x1234 to r3 while reading r3, with r3 previously 0x0001 -> SrcData1 = 0x1234 if BYPASS_EN is defined, else 0x0001.
REQ-033 Fill all 16 registers nonzero, pulse clr -> busy is high for exactly 16 cycles; writes during busy are dropped; all reads return 0 afterward.
REQ-034 Assert rst at sweep cycle 7 -> busy=0 next cycle and all registers read 0; a subsequent write and read of r9 = 0x00AA succeeds.
REQ-035 ZERO_REG=1: write 0xFFFF to r0 with bypass active -> reads of r0 return 0x0000.
REQ-036 DATA_W=32, ADDR_W=5: write 0xDEADBEEF to r31, read it back -> 0xDEADBEEF; clr sweep lasts 32 cycles.
